// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int IFU_WIDTH   = 32;

    typedef struct packed {
        logic [31:0]          pc;
        logic [IFU_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush empties it in one cycle.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr] <= push_data;
    end

    assign head  = mem_q[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns the PC, reads async imem, queues {pc, instr} for decode.
// Optional IFU_MISALIGN_CHECK_EN adds fetch_misaligned and halts on unaligned redirects.
//
// state | meaning
// IDLE  | after reset, no fetch until fetch_en
// RUN   | fetching one word per cycle while the queue has room
// HALT  | no fetch, queue drains, left only via redirect
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          ADDRESS_SIZE = 10,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en,
    input  logic                    halt_req,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic [ADDRESS_SIZE-1:0] imem_addr,
    output logic                    imem_read_en,
    input  logic [WIDTH-1:0]        imem_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [WIDTH-1:0]        out_instr,
    output logic                    halted
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                    fetch_misaligned
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    ifu_state_t       state_q, state_d;
    logic [31:0]      pc_q;
    logic             fetch;
    logic             deq;
    logic             redirect_bad;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misaligned_q;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst)                 misaligned_q <= 1'b0;
        else if (redirect_valid) misaligned_q <= redirect_bad;
    end

    assign fetch_misaligned = misaligned_q;
`else
    assign redirect_bad = 1'b0;
`endif

    assign deq   = out_valid && out_ready;
    assign fetch = (state_q == RUN) && !redirect_valid && !halt_req && (!full || deq);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fetch_en) state_d = RUN;
            RUN:  if (halt_req || redirect_bad) state_d = HALT;
            HALT: if (redirect_valid && !halt_req && !redirect_bad) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Redirect outranks fetch; a redirect in IDLE still loads the PC.
    always_ff @(posedge clk) begin
        if (rst)                 pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= redirect_pc;
        else if (fetch)          pc_q <= pc_q + 32'(INSTR_BYTES);
    end

    ifu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data ('{pc: pc_q, instr: imem_instr}),
        .pop       (deq),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign imem_addr    = pc_q[ADDRESS_SIZE+1:2];
    assign imem_read_en = fetch;
    assign out_valid    = (count != '0);
    assign out_pc       = empty ? 32'h0 : head.pc;
    assign out_instr    = empty ? '0 : head.instr;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized and directed bench for instruction_fetch_unit against a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          M_IDLE   = 0;
    localparam int          M_RUN    = 1;
    localparam int          M_HALT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [9:0]  imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    logic [31:0] imem [1024];

    always #5 clk = ~clk;

    always_comb imem_instr = imem[imem_addr];

    instruction_fetch_unit #(
        .WIDTH        (32),
        .ADDRESS_SIZE (10),
        .RESET_PC     (RST_PC),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_read_en   (imem_read_en),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    int          m_state;
    logic [31:0] m_pc;
    bit          m_mis;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = RST_PC;
        m_mis   = 1'b0;
        q.delete();
    endtask

    // One clock: drive inputs at negedge, compare against model, then advance model at posedge.
    task automatic cycle(input bit r, input bit fe, input bit hr, input bit rv,
                         input logic [31:0] rpc, input bit rdy);
        bit   ev, dq, f, bad;
        ent_t e;
        @(negedge clk);
        rst = r; fetch_en = fe; halt_req = hr; redirect_valid = rv;
        redirect_pc = rpc; out_ready = rdy;
        #1;
        ev = (q.size() != 0);
        dq = ev && rdy;
        f  = (m_state == M_RUN) && !rv && !hr && ((q.size() < DEPTH) || dq);
`ifdef IFU_MISALIGN_CHECK_EN
        bad = rv && (rpc[1:0] != 2'b00);
        check("misaligned", fetch_misaligned, m_mis);
`else
        bad = 1'b0;
`endif
        check("read_en", imem_read_en, f);
        check("imem_addr", imem_addr, m_pc[11:2]);
        check("out_valid", out_valid, ev);
        check("halted", halted, m_state == M_HALT);
        if (ev) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (dq) void'(q.pop_front());
            if (rv) begin
                q.delete();
                m_pc = rpc;
            end else if (f) begin
                e.pc    = m_pc;
                e.instr = imem[m_pc[11:2]];
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (rv) m_mis = bad;
            case (m_state)
                M_IDLE:  if (fe) m_state = M_RUN;
                M_RUN:   if (hr || bad) m_state = M_HALT;
                default: if (rv && !hr && !bad) m_state = M_RUN;
            endcase
        end
    endtask

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        for (int i = 0; i < 4; i++) imem[i] = 32'h0000_0013;
        model_reset();

        // reset state
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_read_en", imem_read_en, 0);
        check("rst_addr", imem_addr, 0);

        // streaming fetch
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        #1;
        check("seq_valid", out_valid, 1);
        check("seq_pc0", out_pc, 32'h0);
        check("seq_instr0", out_instr, 32'h13);
        cycle(0, 1, 0, 0, 0, 1); #1; check("seq_pc1", out_pc, 32'h4);
        cycle(0, 1, 0, 0, 0, 1); #1; check("seq_pc2", out_pc, 32'h8);
        cycle(0, 1, 0, 0, 0, 1); #1; check("seq_pc3", out_pc, 32'hC);

        // backpressure from a fresh reset
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        #1;
        check("bp_read_en", imem_read_en, 0);
        check("bp_addr", imem_addr, 2);
        check("bp_pc0", out_pc, 32'h0);
        cycle(0, 1, 0, 0, 0, 1); #1; check("bp_pc1", out_pc, 32'h4);
        cycle(0, 1, 0, 0, 0, 1); #1; check("bp_pc2", out_pc, 32'h8);

        // redirect while full
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 32'h40, 1);
        #1;
        check("rd_valid", out_valid, 0);
        check("rd_addr", imem_addr, 10'h10);
        cycle(0, 1, 0, 0, 0, 1);
        #1;
        check("rd_valid2", out_valid, 1);
        check("rd_pc", out_pc, 32'h40);

        // halt and resume
        cycle(0, 1, 1, 0, 0, 0);
        #1;
        check("halt_halted", halted, 1);
        check("halt_drain_valid", out_valid, 1);
        cycle(0, 1, 0, 0, 0, 1);
        #1;
        check("halt_read_en", imem_read_en, 0);
        cycle(0, 1, 0, 1, 32'h100, 1);
        cycle(0, 1, 0, 0, 0, 1);
        #1;
        check("resume_halted", halted, 0);
        check("resume_pc", out_pc, 32'h100);

        // simultaneous redirect and halt
        cycle(0, 1, 1, 1, 32'h20, 0);
        #1;
        check("rh_halted", halted, 1);
        check("rh_valid", out_valid, 0);
        check("rh_addr", imem_addr, 10'h8);

        // reset with entries queued
        cycle(0, 1, 0, 1, 32'h200, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        #1;
        check("rq_valid_before", out_valid, 1);
        cycle(1, 1, 0, 0, 0, 0);
        #1;
        check("rq_valid", out_valid, 0);
        check("rq_addr", imem_addr, RST_PC[11:2]);
        check("rq_halted", halted, 0);

`ifdef IFU_MISALIGN_CHECK_EN
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 1, 32'h22, 1);
        #1;
        check("mis_flag", fetch_misaligned, 1);
        check("mis_halted", halted, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                1:       rpc = $urandom & 32'h0000_0FFC;
                default: rpc = $urandom;
            endcase
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 11) == 0,
                  rpc,
                  $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
